nios_ii_system_multi_timer: RTL

NIOS_II_SYSTEM_MULTI_TIMER -- requirements
Module: nios_ii_system_multi_timer

---
 rtl/nios_ii_system_multi_timer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/nios_ii_system_multi_timer.sv
// Avalon-MM multi-channel down-counting interval timer with per-channel IRQ.
// Optional shared tick prescaler at word 16 when MULTI_TIMER_PRESCALER_EN is defined.

module nios_ii_system_multi_timer_ch #(
    parameter int              CNT_W = 32,
    parameter logic [CNT_W-1:0] RST_P = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             wr_status,
    input  logic             wr_ctrl,
    input  logic             wr_period,
    input  logic             wr_snap,
    input  logic [CNT_W-1:0] wdata,
    output logic             running,
    output logic             to,
    output logic [1:0]       ctrl,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] snap
);
    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             run_q, run_d, to_q, to_d;
    logic             timeout;

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        snap_d   = snap_q;
        ctrl_d   = ctrl_q;
        run_d    = run_q;
        timeout  = run_q && tick && (cnt_q == '0);
        if (run_q && tick) begin
            if (timeout) begin
                cnt_d = period_q;
                if (!ctrl_q[1]) run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        // A fresh timeout outranks a concurrent STATUS clear
        to_d = timeout | (to_q & ~wr_status);
        if (wr_ctrl) begin
            ctrl_d = wdata[1:0];
            if (wdata[3])      run_d = 1'b0;
            else if (wdata[2]) run_d = 1'b1;
        end
        if (wr_period) begin
            period_d = wdata;
            cnt_d    = wdata;
            run_d    = 1'b0;
        end
        if (wr_snap) snap_d = cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= RST_P;
            period_q <= RST_P;
            snap_q   <= '0;
            ctrl_q   <= '0;
            run_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            snap_q   <= snap_d;
            ctrl_q   <= ctrl_d;
            run_q    <= run_d;
            to_q     <= to_d;
        end
    end

    assign running = run_q;
    assign to      = to_q;
    assign ctrl    = ctrl_q;
    assign period  = period_q;
    assign snap    = snap_q;
endmodule

module nios_ii_system_multi_timer #(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 49
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);
    localparam logic [CNT_W-1:0] RST_P = CNT_W'(RESET_PERIOD);

    logic                         wr, tick;
    logic [NUM_CH-1:0]            running, to;
    logic [NUM_CH-1:0][1:0]       ctrl;
    logic [NUM_CH-1:0][CNT_W-1:0] period, snap;
    logic [31:0]                  readdata_q, readdata_d;

    assign wr = chipselect && !write_n;

`ifdef MULTI_TIMER_PRESCALER_EN
    logic [7:0] div_q, div_d, pcnt_q, pcnt_d;

    assign tick = (pcnt_q == div_q);

    always_comb begin
        div_d  = div_q;
        pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
        if (wr && address == 5'd16) begin
            div_d  = writedata[7:0];
            pcnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= 8'd0;
            pcnt_q <= 8'd0;
        end else begin
            div_q  <= div_d;
            pcnt_q <= pcnt_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic sel;
        // address[4]=0 is implied since c never exceeds 3
        assign sel = wr && (address[4:2] == 3'(c));

        nios_ii_system_multi_timer_ch #(.CNT_W(CNT_W), .RST_P(RST_P)) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .tick      (tick),
            .wr_status (sel && address[1:0] == 2'd0),
            .wr_ctrl   (sel && address[1:0] == 2'd1),
            .wr_period (sel && address[1:0] == 2'd2),
            .wr_snap   (sel && address[1:0] == 2'd3),
            .wdata     (writedata[CNT_W-1:0]),
            .running   (running[c]),
            .to        (to[c]),
            .ctrl      (ctrl[c]),
            .period    (period[c]),
            .snap      (snap[c])
        );

        assign irq[c] = to[c] && ctrl[c][0];
    end

    assign irq_any = |irq;

    always_comb begin
        readdata_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (address[4:2] == 3'(c)) begin
                case (address[1:0])
                    2'd0: readdata_d = {30'b0, running[c], to[c]};
                    2'd1: readdata_d = {30'b0, ctrl[c]};
                    2'd2: readdata_d = 32'(period[c]);
                    default: readdata_d = 32'(snap[c]);
                endcase
            end
        end
`ifdef MULTI_TIMER_PRESCALER_EN
        if (address == 5'd16) readdata_d = {24'b0, div_q};
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata_q <= '0;
        else          readdata_q <= readdata_d;
    end

    assign readdata = readdata_q;
endmodule
